// File: rtl/ppi_bus_sequencer_if.sv
// Host request/response and PPI bus signals for ppi_bus_sequencer.
// Define PPI_BSR_EN to add the port C bit set/reset request channel.
interface ppi_bus_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic       busy;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic [1:0] A;
  logic [7:0] D_out;
  logic       D_oe;
  logic [7:0] D_in;
`ifdef PPI_BSR_EN
  logic       bsr_valid;
  logic       bsr_ready;
  logic [2:0] bsr_bit;
  logic       bsr_set;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, D_in, bsr_valid, bsr_bit, bsr_set,
    input  req_ready, rsp_valid, rsp_rdata, init_done, busy,
           CS_n, RD_n, WR_n, A, D_out, D_oe, bsr_ready
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, D_in, bsr_valid, bsr_bit, bsr_set,
    output req_ready, rsp_valid, rsp_rdata, init_done, busy,
           CS_n, RD_n, WR_n, A, D_out, D_oe, bsr_ready
  );
`else
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, D_in,
    input  req_ready, rsp_valid, rsp_rdata, init_done, busy,
           CS_n, RD_n, WR_n, A, D_out, D_oe
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, D_in,
    output req_ready, rsp_valid, rsp_rdata, init_done, busy,
           CS_n, RD_n, WR_n, A, D_out, D_oe
  );
`endif
endinterface

// File: rtl/ppi_bus_sequencer.sv
// Host-side bus-cycle controller for an 8255-style PPI: init write, then timed read/write cycles.
// Optional PPI_BSR_EN adds a port C bit set/reset request channel with priority over host requests.
module ppi_bus_sequencer #(
  parameter int         SETUP_CYC      = 1,
  parameter int         STROBE_CYC     = 2,
  parameter int         HOLD_CYC       = 1,
  parameter logic [7:0] INIT_CTRL_WORD = 8'h80
) (
  input logic            clk,
  input logic            Reset,
  ppi_bus_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       txn_wr_q, txn_wr_d;
  logic [1:0] txn_addr_q, txn_addr_d;
  logic [7:0] txn_data_q, txn_data_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       d_oe_q, d_oe_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       init_done_q, init_done_d;
  logic       idle_ready;
  logic       cyc_active;

  assign idle_ready = (state_q == ST_IDLE) && init_done_q;

`ifdef PPI_BSR_EN
  assign bus.bsr_ready = idle_ready;
  assign bus.req_ready = idle_ready && !bus.bsr_valid;
`else
  assign bus.req_ready = idle_ready;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    txn_wr_d    = txn_wr_q;
    txn_addr_d  = txn_addr_q;
    txn_data_d  = txn_data_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;

    case (state_q)
      ST_INIT: begin
        txn_wr_d   = 1'b1;
        txn_addr_d = 2'b11;
        txn_data_d = INIT_CTRL_WORD;
        state_d    = ST_SETUP;
        cnt_d      = SETUP_LD;
      end
      ST_IDLE: begin
`ifdef PPI_BSR_EN
        if (bus.bsr_valid && idle_ready) begin
          txn_wr_d   = 1'b1;
          txn_addr_d = 2'b11;
          txn_data_d = {1'b0, 3'b000, bus.bsr_bit, bus.bsr_set};
          state_d    = ST_SETUP;
          cnt_d      = SETUP_LD;
        end else
`endif
        if (bus.req_valid && bus.req_ready) begin
          txn_wr_d   = bus.req_wr;
          txn_addr_d = bus.req_addr;
          txn_data_d = bus.req_wdata;
          state_d    = ST_SETUP;
          cnt_d      = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Read data is captured on the edge that ends the strobe.
          if (!txn_wr_q) rsp_rdata_d = bus.D_in;
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_IDLE;
          rsp_valid_d = !txn_wr_q;
          init_done_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Bus outputs are registered from the next state so they change cleanly on the edge.
    cyc_active = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    cs_n_d     = !cyc_active;
    rd_n_d     = !((state_d == ST_STROBE) && !txn_wr_d);
    wr_n_d     = !((state_d == ST_STROBE) && txn_wr_d);
    d_oe_d     = cyc_active && txn_wr_d;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= 4'd0;
      txn_wr_q    <= 1'b0;
      txn_addr_q  <= 2'b00;
      txn_data_q  <= 8'h00;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      d_oe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      txn_wr_q    <= txn_wr_d;
      txn_addr_q  <= txn_addr_d;
      txn_data_q  <= txn_data_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      d_oe_q      <= d_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.CS_n      = cs_n_q;
  assign bus.RD_n      = rd_n_q;
  assign bus.WR_n      = wr_n_q;
  assign bus.A         = txn_addr_q;
  assign bus.D_out     = txn_data_q;
  assign bus.D_oe      = d_oe_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.init_done = init_done_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/ppi_bus_sequencer.md
Name: ppi_bus_sequencer

Overview:
- Host-side bus-cycle controller for the 8255-style PPI block.
- Turns single-beat host read/write requests (valid/ready) into properly timed PPI bus cycles on CS_n, RD_n, WR_n, A and the data bus, with programmable setup, strobe and hold lengths.
- After reset, writes a configurable control word to the PPI control register before it accepts host traffic.
- Sits between the system bus adapter and the PPI control logic / data bus buffer.

Parameters:
- SETUP_CYC, 1: cycles with CS_n=0 and A stable before the strobe; legal range 1..15.
- STROBE_CYC, 2: cycles RD_n or WR_n is held low; legal range 1..15.
- HOLD_CYC, 1: cycles after the strobe with CS_n=0, A and write data held; legal range 1..15.
- INIT_CTRL_WORD, 8'h80: mode word written to A=2'b11 after reset (all ports mode 0, outputs).

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  sequencer accepts the request this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  2  PPI port select (00 A, 01 B, 10 C, 11 control).
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_rdata  out  8  captured read data.
- init_done  out  1  init write complete.
- busy  out  1  high whenever state is not IDLE.
- CS_n  out  1  PPI chip select, active low.
- RD_n  out  1  PPI read strobe, active low.
- WR_n  out  1  PPI write strobe, active low.
- A  out  2  PPI address.
- D_out  out  8  data driven to PPI.
- D_oe  out  1  data bus output enable.
- D_in  in  8  data from PPI.

Behaviour:
- Reset values: CS_n=1, RD_n=1, WR_n=1, A=00, D_out=00, D_oe=0, rsp_valid=0, rsp_rdata=00, init_done=0, busy=1, state=INIT.
- Reset asserted mid-cycle aborts the transaction on the next edge:
  - strobes and CS_n return high immediately;
  - no rsp_valid is produced;
  - the init write is repeated.
- FSM states: INIT, IDLE, SETUP, STROBE, HOLD.
  - INIT: one cycle. Loads the internal transaction {wr=1, A=11, data=INIT_CTRL_WORD}, then goes to SETUP.
  - IDLE: CS_n=1, D_oe=0.
  - req_ready = (state==IDLE) && init_done; combinational.
  - On req_valid && req_ready: latch wr, addr and wdata, then go to SETUP.
- SETUP, SETUP_CYC cycles:
  - CS_n=0, A=latched addr, RD_n=WR_n=1.
  - D_oe=wr, D_out=wdata.
- STROBE, STROBE_CYC cycles:
  - RD_n=0 for reads, WR_n=0 for writes.
  - Read: D_in is sampled into rsp_rdata on the last STROBE cycle's edge.
- HOLD, HOLD_CYC cycles:
  - RD_n=WR_n=1; CS_n, A, D_out and D_oe held.
  - Then go to IDLE.
- All PPI-side outputs are registered; no glitches.
- Dwell counter is 4-bit, reloaded at every state entry.
- Timing, with the accept edge at cycle T:
  - SETUP spans T+1..T+SETUP_CYC.
  - STROBE follows for STROBE_CYC cycles, then HOLD for HOLD_CYC cycles.
  - IDLE is re-entered at T+SETUP_CYC+STROBE_CYC+HOLD_CYC+1.
- rsp_valid pulses for exactly that first IDLE cycle, after reads only. Writes produce no response.
- Back-to-back requests: accepted in the first IDLE cycle, so CS_n is guaranteed high for at least 1 cycle between transactions.
- init_done rises on the first IDLE entry after reset and stays high until the next Reset. Host requests are stalled (req_ready=0) until then.
- A host write to A=11 is passed through unmodified; the sequencer does not track the PPI mode.
- req_valid deasserted while req_ready=0 is legal. Request fields are sampled only at acceptance.

Optional Feature:
- Macro: PPI_BSR_EN.
- With the macro defined, extra ports are added:
  - bsr_valid  in  1
  - bsr_ready  out  1
  - bsr_bit  in  3
  - bsr_set  in  1
- bsr_ready = (state==IDLE) && init_done.
- On acceptance, the sequencer runs a write to A=11 with data {1'b0,3'b000,bsr_bit,bsr_set}, the port C bit set/reset word.
- BSR has priority: req_ready = (state==IDLE) && init_done && !bsr_valid.
- Without the macro: these ports do not exist, and req_ready is as defined in Behaviour.

Test Plan:
- Reset with default params → CS_n=0 for cycles 2..5 after reset release, A=11, D_out=80, WR_n=0 on cycles 3–4. init_done=1 and req_ready=1 on cycle 6.
- Read A=01 with D_in=5A (defaults), accepted at T → RD_n=0 at T+2..T+3, rsp_valid=1 and rsp_rdata=5A at T+5, rsp_valid=0 at T+6.
- Write A=00 data=C3 with SETUP_CYC=3, STROBE_CYC=4, HOLD_CYC=2 → WR_n low for exactly 4 cycles, D_oe=1 for 9 cycles, next req_ready at T+10.
- Two back-to-back reads with req_valid held high → CS_n high for exactly 1 cycle between them, two rsp_valid pulses 5 cycles apart.
- Reset asserted during STROBE of a write → on the next edge WR_n=1, CS_n=1 and D_oe=0, no rsp_valid, then the init write (A=11, data=80) repeats.
- PPI_BSR_EN with bsr_valid and req_valid asserted together, bsr_bit=5, bsr_set=1 → BSR write of 0B to A=11 runs first, and the host request is accepted in the following IDLE cycle.
